tone_gen: RTL and testbench

Downstream consumer of the button frequency lookup. Takes the 9-bit note frequency in Hz (0 = pause) and drives a 50%-duty square wave on the speaker pin. The half-period count is computed once per note change by an iterative restoring divider, so no hardware divider sits in the per-cycle path. It sits between the button frequency LUT and the board's speaker/buzzer pin.

---
 rtl/tone_gen_pkg.sv | 23 ++
 rtl/tone_gen_seq_divider.sv | 92 +++++++++
 rtl/tone_gen.sv | 133 +++++++++++++
 tb/tb_tone_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tone_gen_pkg.sv
//==============================================================================
// Module      : tone_pkg
// Description : Shared state encoding and width helper for the tone generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tone_pkg;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        CALC   = 2'd1,
        PLAY   = 2'd2
    } tone_state_t;

    // Bits needed to hold the half-period count for a given clock frequency.
    function automatic int calc_qw(input int clk_hz);
        return $clog2(clk_hz / 2 + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tone_gen_seq_divider.sv
//==============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider #(
    parameter int DW = 25,
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);

    localparam int CW = $clog2(DW + 1);

    logic [VW-1:0] r_rem;
    logic [VW-1:0] r_div;
    logic [DW-1:0] r_quo;
    logic [CW-1:0] r_left;
    logic          r_busy;
    logic          r_done;

    logic [VW-1:0] w_rem_in;
    logic [VW-1:0] w_div_in;
    logic [DW-1:0] w_quo_in;
    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;
    logic [VW-1:0] w_rem_out;
    logic [DW-1:0] w_quo_out;

    // The start cycle already performs the first step on the fresh operands,
    // so the final quotient is ready DW edges after start.
    always_comb begin
        if (start) begin
            w_rem_in = '0;
            w_quo_in = dividend;
            w_div_in = divisor;
        end else begin
            w_rem_in = r_rem;
            w_quo_in = r_quo;
            w_div_in = r_div;
        end
        w_trial   = {w_rem_in, w_quo_in[DW-1]};
        w_diff    = w_trial - {1'b0, w_div_in};
        w_ge      = (w_trial >= {1'b0, w_div_in});
        w_rem_out = w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
        w_quo_out = {w_quo_in[DW-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_left <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_out;
                r_quo  <= w_quo_out;
                r_div  <= divisor;
                r_left <= CW'(DW - 1);
                r_busy <= (DW > 1);
                r_done <= (DW == 1);
            end else if (r_busy) begin
                r_rem  <= w_rem_out;
                r_quo  <= w_quo_out;
                r_left <= r_left - CW'(1);
                if (r_left == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: rtl/tone_gen.sv
//==============================================================================
// Module      : tone_gen
// Description : 50%-duty square-wave tone generator driven by a note frequency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int QW     = calc_qw(CLK_HZ)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [8:0]    buttonFreq,
    output logic          speaker,
    output logic          busy,
    output logic [QW-1:0] half_period
);

    localparam logic [QW-1:0] c_dividend = QW'(CLK_HZ / 2);
    localparam logic [QW-1:0] c_one      = QW'(1);

    tone_state_t   r_state;
    tone_state_t   w_state_nxt;
    logic [8:0]    r_freq;
    logic [8:0]    r_note;
    logic [8:0]    w_note_nxt;
    logic [QW-1:0] r_cnt;
    logic [QW-1:0] r_hp;
    logic          r_spk;
    logic          w_changed;
    logic          w_div_start;
    logic          w_play_go;
    logic [QW-1:0] w_quo;
    logic          w_div_done;

    // The divisor is taken from r_freq because r_note only catches up on the
    // same edge that launches the divider.
    seq_divider #(
        .DW (QW),
        .VW (9)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (w_div_start),
        .dividend (c_dividend),
        .divisor  (r_freq),
        .quotient (w_quo),
        .done     (w_div_done)
    );

    assign w_changed = (r_freq != r_note);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SILENT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_div_start = 1'b0;
        w_play_go   = 1'b0;
        case (r_state)
            SILENT: begin
                if (r_freq == 9'd0) begin
                    w_note_nxt = 9'd0;
                end else if (w_changed) begin
                    w_note_nxt  = r_freq;
                    w_div_start = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC, PLAY: begin
                // A note change outranks a divider finishing on the same edge.
                if (w_changed) begin
                    if (r_freq == 9'd0) begin
                        w_note_nxt  = 9'd0;
                        w_state_nxt = SILENT;
                    end else begin
                        w_note_nxt  = r_freq;
                        w_div_start = 1'b1;
                        w_state_nxt = CALC;
                    end
                end else if ((r_state == CALC) && w_div_done) begin
                    w_play_go   = 1'b1;
                    w_state_nxt = PLAY;
                end
            end
            default: begin
                w_state_nxt = SILENT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_freq <= '0;
            r_note <= '0;
            r_cnt  <= '0;
            r_hp   <= '0;
            r_spk  <= 1'b0;
        end else begin
            r_freq <= buttonFreq;
            r_note <= w_note_nxt;
            if (w_play_go) begin
                r_hp  <= w_quo;
                r_cnt <= '0;
                r_spk <= 1'b1;
            end else if (w_state_nxt != PLAY) begin
                r_cnt <= '0;
                r_spk <= 1'b0;
            end else if (r_cnt == r_hp - c_one) begin
                r_cnt <= '0;
                r_spk <= ~r_spk;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign speaker     = r_spk;
    assign busy        = (r_state == CALC);
    assign half_period = r_hp;

endmodule

`default_nettype wire

// File: tb/tb_tone_gen.sv
//==============================================================================
// Module      : tb_tone_gen
// Description : Self-checking bench for tone_gen against a timing-rule model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tone_gen;

    localparam int CLK_HZ = 100_000;
    localparam int QW     = 16;
    localparam int HALF   = CLK_HZ / 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [8:0]    buttonFreq = '0;
    logic          speaker;
    logic          busy;
    logic [QW-1:0] half_period;

    tone_gen #(
        .CLK_HZ (CLK_HZ),
        .QW     (QW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buttonFreq  (buttonFreq),
        .speaker     (speaker),
        .busy        (busy),
        .half_period (half_period)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: the registered frequency currently held (m_v), the edge at
    // which that value was first registered (m_s) and the last half period
    // that reached playback (m_hp).
    int edge_n = 0;
    int m_v    = 0;
    int m_s    = 0;
    int m_hp   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic cycle(input int bf, input bit rn);
        logic e_spk;
        logic e_busy;
        @(negedge clk);
        buttonFreq = 9'(bf);
        reset_n    = rn;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            e_spk  = 1'b0;
            e_busy = 1'b0;
            m_hp   = 0;
            m_v    = 0;
            m_s    = edge_n;
        end else begin
            if (m_v == 0) begin
                e_spk  = 1'b0;
                e_busy = 1'b0;
            end else if (edge_n < m_s + 1 + QW) begin
                e_spk  = 1'b0;
                e_busy = 1'b1;
            end else begin
                m_hp   = HALF / m_v;
                e_busy = 1'b0;
                e_spk  = (((edge_n - (m_s + 1 + QW)) / m_hp) % 2) == 0;
            end
            if (bf != m_v) begin
                m_v = bf;
                m_s = edge_n;
            end
        end
        #1;
        check("speaker", 32'(speaker), 32'(e_spk));
        check("busy", 32'(busy), 32'(e_busy));
        check("half_period", 32'(half_period), 32'(m_hp));
    endtask

    task automatic hold(input int bf, input int n);
        for (int i = 0; i < n; i++) cycle(bf, 1'b1);
    endtask

    initial begin
        int bf;
        int len;
        int r;

        for (int i = 0; i < 3; i++) cycle(0, 1'b0);
        hold(0, 100);
        check("idle_hp", 32'(half_period), 32'd0);

        // 220 Hz: busy for QW cycles, then ten full periods of 454 clocks.
        hold(220, QW + 2 + 10 * 2 * 227 + 5);
        check("hp_220", 32'(half_period), 32'd227);

        // Abort a CALC five cycles in with 440 Hz.
        hold(0, 5);
        hold(220, 6);
        hold(440, QW + 2 + 3 * 2 * 113);
        check("hp_440", 32'(half_period), 32'd113);

        // 511 Hz then silence.
        hold(511, QW + 2 + 150);
        hold(0, 60);
        check("silent_spk", 32'(speaker), 32'd0);

        // 392 Hz with a one-cycle reset mid-period.
        hold(392, QW + 2 + 190);
        cycle(392, 1'b0);
        check("rst_hp", 32'(half_period), 32'd0);
        hold(392, QW + 2 + 300);
        check("hp_392", 32'(half_period), 32'd127);

        // Rapid toggling keeps the divider restarting; PLAY never entered.
        for (int i = 0; i < 17; i++) hold((i % 2) ? 294 : 262, 3);
        hold(294, QW + 2 + 400);
        check("hp_294", 32'(half_period), 32'd170);

        // Randomised segments, including short glitches, silence and resets.
        for (int seg = 0; seg < 40; seg++) begin
            r   = int'($urandom_range(0, 9));
            bf  = (r == 0) ? 0 : int'($urandom_range(1, 511));
            len = (r < 3) ? int'($urandom_range(1, 4)) : int'($urandom_range(10, 300));
            if ($urandom_range(0, 19) == 0) cycle(bf, 1'b0);
            hold(bf, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
